// File: rtl/simmem_arbiter_if.sv
// Requester and memory-port bundle for simmem_arbiter.
// slave: arbiter side; master: requesters plus the SimMem model.
interface simmem_arbiter_if;
    logic        req0_stb;
    logic        req0_we;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req0_ack;
    logic        req0_err;
    logic [31:0] req0_rdata;

    logic        req1_stb;
    logic        req1_we;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_ack;
    logic        req1_err;
    logic [31:0] req1_rdata;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0_stb, req0_we, req0_addr, req0_wdata,
        output req0_ack, req0_err, req0_rdata,
        input  req1_stb, req1_we, req1_addr, req1_wdata,
        output req1_ack, req1_err, req1_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0_stb, req0_we, req0_addr, req0_wdata,
        input  req0_ack, req0_err, req0_rdata,
        output req1_stb, req1_we, req1_addr, req1_wdata,
        input  req1_ack, req1_err, req1_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/simmem_arbiter.sv
// Two-way round-robin arbiter in front of one SimMem port, with local error completion.
// Optional statistics counters: define SIMMEM_ARBITER_STATS_EN.
module simmem_arbiter #(
    parameter logic [31:0] BASE   = 32'h1000,
    parameter logic [31:0] SIZE   = (1 << 24) - 32'h1000,
    parameter int unsigned RD_LAT = 1
`ifdef SIMMEM_ARBITER_STATS_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic            clk,
    input  logic            reset,
    simmem_arbiter_if.slave bus,
    output logic            busy
`ifdef SIMMEM_ARBITER_STATS_EN
    ,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    // Window bounds in 33 bits so BASE+SIZE cannot wrap.
    localparam logic [32:0] WIN_LO    = {1'b0, BASE};
    localparam logic [32:0] WIN_HI    = {1'b0, BASE} + {1'b0, SIZE};
    localparam logic [2:0]  WAIT_INIT = 3'(RD_LAT - 1);

    state_t      state, state_nx;
    logic        last_grant, last_grant_nx;
    logic        gnt, gnt_nx;
    logic        l_we, l_we_nx;
    logic [2:0]  wait_cnt, wait_cnt_nx;

    logic        any_stb, both_stb, sel, grant, rd_done;
    logic        pick_we, pick_ok;
    logic [31:0] pick_addr, pick_wdata;

    logic        mem_we_nx, busy_nx;
    logic [31:0] mem_addr_nx, mem_wdata_nx;
    logic        ack0_nx, ack1_nx, err0_nx, err1_nx;
    logic [31:0] rdata0_nx, rdata1_nx;

    assign any_stb    = bus.req0_stb | bus.req1_stb;
    assign both_stb   = bus.req0_stb & bus.req1_stb;
    assign sel        = both_stb ? ~last_grant : bus.req1_stb;
    assign pick_we    = sel ? bus.req1_we    : bus.req0_we;
    assign pick_addr  = sel ? bus.req1_addr  : bus.req0_addr;
    assign pick_wdata = sel ? bus.req1_wdata : bus.req0_wdata;
    assign pick_ok    = ({1'b0, pick_addr} >= WIN_LO) && ({1'b0, pick_addr} < WIN_HI);
    assign grant      = (state == IDLE) && any_stb;
    assign rd_done    = (state == ISSUE && !l_we && RD_LAT == 0) ||
                        (state == WAIT && wait_cnt == 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_stb) state_nx = pick_ok ? ISSUE : DONE;
            ISSUE:   state_nx = (l_we || RD_LAT == 0) ? DONE : WAIT;
            WAIT:    if (wait_cnt == 3'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs and grant latches, derived from state_nx.
    always_comb begin
        gnt_nx        = grant ? sel : gnt;
        l_we_nx       = grant ? pick_we : l_we;
        last_grant_nx = grant ? sel : last_grant;
        wait_cnt_nx   = '0;
        if (state_nx == WAIT)
            wait_cnt_nx = (state == WAIT) ? wait_cnt - 3'd1 : WAIT_INIT;

        mem_we_nx    = (state_nx == ISSUE) && pick_we;
        mem_addr_nx  = (state_nx == ISSUE) ? pick_addr  : bus.mem_addr;
        mem_wdata_nx = (state_nx == ISSUE) ? pick_wdata : bus.mem_wdata;

        ack0_nx   = (state_nx == DONE) && !gnt_nx;
        ack1_nx   = (state_nx == DONE) &&  gnt_nx;
        err0_nx   = grant && !pick_ok && !sel;
        err1_nx   = grant && !pick_ok &&  sel;
        rdata0_nx = (rd_done && !gnt) ? bus.mem_rdata : '0;
        rdata1_nx = (rd_done &&  gnt) ? bus.mem_rdata : '0;
        busy_nx   = (state_nx != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant     <= 1'b1;
            gnt            <= 1'b0;
            l_we           <= 1'b0;
            wait_cnt       <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.req0_ack   <= 1'b0;
            bus.req1_ack   <= 1'b0;
            bus.req0_err   <= 1'b0;
            bus.req1_err   <= 1'b0;
            bus.req0_rdata <= '0;
            bus.req1_rdata <= '0;
            busy           <= 1'b0;
        end else begin
            last_grant     <= last_grant_nx;
            gnt            <= gnt_nx;
            l_we           <= l_we_nx;
            wait_cnt       <= wait_cnt_nx;
            bus.mem_we     <= mem_we_nx;
            bus.mem_addr   <= mem_addr_nx;
            bus.mem_wdata  <= mem_wdata_nx;
            bus.req0_ack   <= ack0_nx;
            bus.req1_ack   <= ack1_nx;
            bus.req0_err   <= err0_nx;
            bus.req1_err   <= err1_nx;
            bus.req0_rdata <= rdata0_nx;
            bus.req1_rdata <= rdata1_nx;
            busy           <= busy_nx;
        end
    end

`ifdef SIMMEM_ARBITER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant0_cnt   <= '0;
            grant1_cnt   <= '0;
            err_cnt      <= '0;
            conflict_cnt <= '0;
        end else if (grant) begin
            if (!sel && grant0_cnt != '1) grant0_cnt <= grant0_cnt + 1'b1;
            if ( sel && grant1_cnt != '1) grant1_cnt <= grant1_cnt + 1'b1;
            if (!pick_ok && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (both_stb && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_simmem_arbiter.sv
// Randomized bench for simmem_arbiter against a transaction-level model with its own memory.
// Define SIMMEM_ARBITER_STATS_EN to also check the statistics counters.
module tb_simmem_arbiter;
    localparam logic [31:0] BASE   = 32'h1000;
    localparam logic [31:0] SIZE   = 32'h00FF_F000;
    localparam int unsigned RD_LAT = 1;
`ifdef SIMMEM_ARBITER_STATS_EN
    localparam int unsigned CNT_W  = 2;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    always #5 clk = ~clk;

    simmem_arbiter_if bus ();

`ifdef SIMMEM_ARBITER_STATS_EN
    logic [CNT_W-1:0] g0c, g1c, ec, cc;
    simmem_arbiter #(.BASE(BASE), .SIZE(SIZE), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy),
        .grant0_cnt(g0c), .grant1_cnt(g1c), .err_cnt(ec), .conflict_cnt(cc)
    );
`else
    simmem_arbiter #(.BASE(BASE), .SIZE(SIZE), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy)
    );
`endif

    // SimMem stand-in: synchronous read (one cycle), read-before-write.
    logic [31:0] sim_mem [logic [31:0]];
    always @(posedge clk) begin
        logic [31:0] rv;
        rv = sim_mem.exists(bus.mem_addr) ? sim_mem[bus.mem_addr] : 32'h0;
        if (bus.mem_we) sim_mem[bus.mem_addr] = bus.mem_wdata;
        bus.mem_rdata <= rv;
    end

    // Reference model state
    logic [31:0] ref_mem [logic [31:0]];
    bit m_last;
    int n_g0, n_g1, n_err, n_conf, n_wr_exp;
    int n_we_seen, n_we_oor;
    int total, bad;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(SIZE));
    endfunction

    function automatic int exp_lat(input op_t o);
        if (!in_rng(o.addr)) return 1;
        return o.we ? 2 : 2 + int'(RD_LAT);
    endfunction

    always @(negedge clk) begin
        if (bus.mem_we) begin
            n_we_seen++;
            if (!in_rng(bus.mem_addr)) n_we_oor++;
        end
    end

    function automatic logic ack_of(input int r);
        return (r != 0) ? bus.req1_ack : bus.req0_ack;
    endfunction
    function automatic logic err_of(input int r);
        return (r != 0) ? bus.req1_err : bus.req0_err;
    endfunction
    function automatic logic [31:0] rdata_of(input int r);
        return (r != 0) ? bus.req1_rdata : bus.req0_rdata;
    endfunction

    task automatic drive(input int r, input bit stb, input op_t o);
        if (r == 0) begin
            bus.req0_stb = stb; bus.req0_we = o.we; bus.req0_addr = o.addr; bus.req0_wdata = o.wdata;
        end else begin
            bus.req1_stb = stb; bus.req1_we = o.we; bus.req1_addr = o.addr; bus.req1_wdata = o.wdata;
        end
    endtask

    function automatic op_t rand_op();
        op_t o;
        o.we    = 1'($urandom_range(0, 1));
        o.wdata = $urandom();
        case ($urandom_range(0, 7))
            0, 1, 2, 3: o.addr = BASE + 32'($urandom_range(0, 15));
            4:          o.addr = 32'h00FF_FFFF - 32'($urandom_range(0, 1));
            5:          o.addr = BASE - 32'd1;
            6:          o.addr = 32'h0100_0000 + 32'($urandom_range(0, 1));
            default:    o.addr = $urandom();
        endcase
        return o;
    endfunction

    task automatic model_reset();
        m_last = 1'b1;
        n_g0 = 0; n_g1 = 0; n_err = 0; n_conf = 0;
    endtask

    // Completion of one access in grant order: update model memory and counters.
    task automatic model_complete(input int r, input op_t o, output bit e, output logic [31:0] rd);
        e  = !in_rng(o.addr);
        rd = '0;
        m_last = (r != 0);
        if (r == 0) n_g0++; else n_g1++;
        if (e) n_err++;
        else if (o.we) begin
            ref_mem[o.addr] = o.wdata;
            n_wr_exp++;
        end else if (ref_mem.exists(o.addr)) rd = ref_mem[o.addr];
    endtask

    // Counts rising edges from the current point until requester r is acked.
    task automatic serve(input int r, input op_t o, input int lat, input bit scramble,
                         input string tag, output logic [31:0] rd);
        int          k_ack;
        bit          e_exp;
        logic [31:0] rd_exp;
        k_ack = 0;
        for (int k = 1; k <= lat + 4 && k_ack == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack_of(r)) k_ack = k;
            else if (scramble && busy) drive(r, 1'b1, rand_op());
        end
        rd = rdata_of(r);
        model_complete(r, o, e_exp, rd_exp);
        check_eq({tag, "_lat"}, k_ack, lat);
        check_eq({tag, "_err"}, {31'd0, err_of(r)}, {31'd0, e_exp});
        check_eq({tag, "_rdata"}, rdata_of(r), rd_exp);
        check_eq({tag, "_other"}, {29'd0, ack_of(1 - r), err_of(1 - r), |rdata_of(1 - r)}, 32'd0);
        drive(r, 1'b0, o);
    endtask

    task automatic single(input int r, input op_t o, input bit scramble, input string tag,
                          output logic [31:0] rd);
        @(negedge clk);
        drive(r, 1'b1, o);
        serve(r, o, exp_lat(o), scramble, tag, rd);
    endtask

    task automatic pair(input op_t o0, input op_t o1, input string tag);
        int          f, s;
        logic [31:0] rd;
        f = m_last ? 0 : 1;
        s = 1 - f;
        @(negedge clk);
        drive(0, 1'b1, o0);
        drive(1, 1'b1, o1);
        n_conf++;
        serve(f, (f != 0) ? o1 : o0, exp_lat((f != 0) ? o1 : o0), 1'b0, {tag, "_a"}, rd);
        serve(s, (s != 0) ? o1 : o0, exp_lat((s != 0) ? o1 : o0) + 1, 1'b0, {tag, "_b"}, rd);
    endtask

`ifdef SIMMEM_ARBITER_STATS_EN
    function automatic int sat(input int n);
        int mx;
        mx = (1 << CNT_W) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic check_stats(input string tag);
        check_eq({tag, "_g0"},   32'(g0c), sat(n_g0));
        check_eq({tag, "_g1"},   32'(g1c), sat(n_g1));
        check_eq({tag, "_err"},  32'(ec),  sat(n_err));
        check_eq({tag, "_conf"}, 32'(cc),  sat(n_conf));
    endtask
`endif

    initial begin
        op_t         o, o2;
        logic [31:0] rd;
        total = 0; bad = 0; n_wr_exp = 0; n_we_seen = 0; n_we_oor = 0;
        o = '0;
        drive(0, 1'b0, o);
        drive(1, 1'b0, o);
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ack", {30'd0, bus.req0_ack, bus.req1_ack}, 32'd0);
        check_eq("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
        check_eq("rst_rdata", bus.req0_rdata | bus.req1_rdata, 32'd0);
        reset = 1'b0;

        // Contention: first tie goes to req0, then strict alternation.
        for (int i = 0; i < 4; i++) begin
            o.we = 1'b1; o.addr = 32'h1100 + 32'(i); o.wdata = 32'hA000_0000 + 32'(i);
            o2.we = 1'b0; o2.addr = 32'h1100 + 32'(i); o2.wdata = 32'h0;
            pair(o, o2, "contend");
            if (i == 2) begin
                o.we = 1'b0; o.addr = 32'h0000_0FFF; o.wdata = 32'h0;
                single(1, o, 1'b0, "oor_fff", rd);
`ifdef SIMMEM_ARBITER_STATS_EN
                check_stats("stats_dir");
`endif
            end
        end

        o.we = 1'b1; o.addr = 32'h1000; o.wdata = 32'hDEAD_BEEF;
        single(0, o, 1'b1, "wr_1000", rd);
        o.we = 1'b0;
        single(0, o, 1'b1, "rd_1000", rd);
        check_eq("rd_1000_val", rd, 32'hDEAD_BEEF);

        o.we = 1'b0; o.addr = 32'h0100_0000;
        single(1, o, 1'b0, "oor_hi", rd);
        o.we = 1'b1; o.addr = 32'h00FF_FFFF; o.wdata = 32'h5A5A_1234;
        single(0, o, 1'b0, "bnd_wr", rd);
        o.we = 1'b0;
        single(1, o, 1'b0, "bnd_rd", rd);
        check_eq("bnd_rd_val", rd, 32'h5A5A_1234);
        o.we = 1'b1; o.addr = 32'h0000_0FFF;
        single(0, o, 1'b0, "bnd_lo", rd);

        // Reset during ISSUE of a write; held strobe is re-granted as a read.
        o.we = 1'b1; o.addr = 32'h2000; o.wdata = 32'h1234_5678;
        single(0, o, 1'b0, "pre_2000", rd);
        @(negedge clk);
        o.wdata = 32'hBADB_AD00;
        drive(0, 1'b1, o);
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_we_hi", {31'd0, bus.mem_we}, 32'd1);
        n_wr_exp++;
        #1 reset = 1'b1;
        #1 check_eq("abort_we_drop", {31'd0, bus.mem_we}, 32'd0);
        o.we = 1'b0;
        drive(0, 1'b1, o);
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_quiet", {30'd0, bus.req0_ack, busy}, 32'd0);
        reset = 1'b0;
        model_reset();
        serve(0, o, exp_lat(o), 1'b0, "regrant", rd);
        check_eq("regrant_val", rd, 32'h1234_5678);

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            case ($urandom_range(0, 2))
                0:       single(0, rand_op(), 1'b1, "rnd0", rd);
                1:       single(1, rand_op(), 1'b1, "rnd1", rd);
                default: pair(rand_op(), rand_op(), "rndp");
            endcase
        end

        repeat (2) @(negedge clk);
        check_eq("we_cycles", n_we_seen, n_wr_exp);
        check_eq("we_out_of_range", n_we_oor, 32'd0);
`ifdef SIMMEM_ARBITER_STATS_EN
        check_stats("stats_end");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simmem_arbiter.md
Name: simmem_arbiter

Overview:
Round-robin arbiter sharing one SimMem port between two requesters (e.g. CPU data side and a loader/DMA engine).
- Per requester: strobe/ack handshake.
- Requests are latched at grant time.
- Memory port is sequenced through issue/wait/complete states.
- Accesses outside the simulated window are completed locally with an error flag; memory is not touched.

Parameters:
- BASE, 32'h1000, first valid word address of the memory window.
- SIZE, (1<<24)-32'h1000, number of valid words; valid range is BASE <= addr < BASE+SIZE.
- RD_LAT, 1, cycles (0..7) between the issue cycle and read-data capture.
- CNT_W, 16, width of the optional statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_stb  in  1  requester 0 access request.
- req0_we  in  1  requester 0 write (1) / read (0).
- req0_addr  in  32  requester 0 word address.
- req0_wdata  in  32  requester 0 write data.
- req0_ack  out  1  requester 0 completion pulse.
- req0_err  out  1  requester 0 out-of-range flag, valid with ack.
- req0_rdata  out  32  requester 0 read data, valid with ack.
- req1_*  same set as req0_*, for requester 1.
- mem_we  out  1  memory write enable (drives SimMem wea).
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous) forces:
  - state=IDLE, all outputs 0.
  - last_grant=1, so requester 0 wins the first tie.
  - Internal latches cleared.
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - Samples req0_stb/req1_stb.
  - One strobe high: grant that requester.
  - Both high: grant the requester != last_grant.
  - On grant:
    - latch we, addr and wdata from the granted requester;
    - set last_grant to the granted requester;
    - evaluate range.
  - In range: go to ISSUE. Out of range: go to DONE with err=1.
- ISSUE (1 cycle):
  - mem_addr = latched addr; mem_wdata = latched data; mem_we = latched we.
  - Write: go to DONE.
  - Read: go to WAIT if RD_LAT>0; otherwise capture mem_rdata at the closing edge and go to DONE.
- WAIT:
  - mem_addr held, mem_we=0.
  - Counts RD_LAT cycles; on the edge ending the last one, captures mem_rdata and goes to DONE.
- mem_we is high only in ISSUE of a write. mem_addr and mem_wdata retain their last value when idle.
- DONE (1 cycle):
  - Granted requester sees ack=1; err and rdata are valid in the same cycle.
  - rdata is 0 for writes and for errors. The other requester's outputs stay 0.
  - Next state is IDLE unconditionally.
- Latency from the stb-sampling edge:
  - write ack: cycle +2;
  - read ack: cycle +2+RD_LAT;
  - error ack: cycle +1.
- Requester rules:
  - Hold stb until ack.
  - Drop stb in the cycle after ack, otherwise it is treated as a new request.
  - addr, we and wdata may change after the grant edge.
- Strobes arriving while busy wait, un-acked, until IDLE. Alternating grants are guaranteed under continuous contention.
- Range compare is unsigned 32-bit. BASE+SIZE is computed in 33 bits, so no wrap-around.
- Reset mid-access: an in-flight write in ISSUE is aborted (mem_we drops immediately). No ack is produced.

Optional Feature:
- Macro: SIMMEM_ARBITER_STATS_EN.
- Defined, adds outputs:
  - grant0_cnt, grant1_cnt, err_cnt, each CNT_W wide;
  - conflict_cnt, CNT_W wide: IDLE grants where both stb were high.
- Counter behaviour:
  - increment on the grant edge;
  - saturate at all-ones;
  - clear on reset.
- Undefined: no such ports or logic exist. Behaviour is otherwise identical.

Test Plan:
- Write then read, req0: addr 0x1000 data 0xDEADBEEF, then read 0x1000 -> ack after 2 cycles (write) and 3 cycles (read, RD_LAT=1); rdata 0xDEADBEEF, err=0.
- Simultaneous stb, both held for 4 requests each -> grants alternate 0,1,0,1...; first grant goes to req0 after reset.
- Out-of-range, req1 reads 0x0FFF and 0x01000000 -> ack at cycle +1, err=1, rdata 0, mem_we never asserted.
- Boundary, addr 0x00FFFFFF -> in range, read/write succeed; addr 0x00000FFF -> err=1.
- Reset pulse during ISSUE of a write to 0x2000 -> mem_we falls asynchronously, no ack, later read of 0x2000 returns prior contents; stb held across reset is re-granted from IDLE.
- With SIMMEM_ARBITER_STATS_EN defined, 3 contended plus 1 error request -> conflict_cnt=3, err_cnt=1, grant counts match; CNT_W=2 saturates at 3.
